// File: rtl/shift_pkg.sv
// shift_pkg: mode and state encodings shared by the sequential shifter and its step unit.
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// shift_step: shifts acc by k (0..STEP) positions in one of the four shift modes.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0]           acc,
    input  logic [$clog2(STEP+1)-1:0]  k,
    input  shift_mode_e                mode,
    input  logic                       sign,
    output logic [WIDTH-1:0]           res
);

    // Arithmetic fill uses the sign captured at accept, so partial steps compose exactly.
    always_comb
        res = mode == SLL ? acc << k :
              mode == SRL ? acc >> k :
              mode == SRA ? (sign ? ~(~acc >> k) : acc >> k) :
              (acc << k) | (acc >> (WIDTH - int'(k)));

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: iterative shifter/rotator moving at most STEP positions per clock,
// with valid/ready handshakes on request and result.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int KW = $clog2(STEP + 1);

    shift_state_e     state;
    shift_mode_e      mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [SHW-1:0]   rem;
    logic [SHW-1:0]   rem_nxt;
    logic [KW-1:0]    k;
    logic             sign;

    // rem is compared as an int so STEP == WIDTH still fits the comparison.
    assign k         = (int'(rem) < STEP) ? KW'(rem) : KW'(STEP);
    assign rem_nxt   = rem - SHW'(k);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_data  = acc;

    shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .acc  (acc),
        .k    (k),
        .mode (mode),
        .sign (sign),
        .res  (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mode  <= SLL;
            acc   <= '0;
            rem   <= '0;
            sign  <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                acc   <= in_data;
                rem   <= in_shamt;
                mode  <= shift_mode_e'(in_mode);
                sign  <= in_data[WIDTH-1];
                state <= in_shamt == '0 ? DONE : SHIFT;
            end
        end else if (state == SHIFT) begin
            acc   <= acc_nxt;
            rem   <= rem_nxt;
            state <= rem_nxt == '0 ? DONE : SHIFT;
        end else begin
            state <= out_ready ? IDLE : DONE;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed vectors for seq_shifter (WIDTH 32, STEP 4).
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    seq_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Accepts one request and returns the number of edges after E0 until out_valid.
    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m, output int lat);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        in_shamt = 5'd31;
        in_mode  = ~m;
        while (lat < 40) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] d, input logic [4:0] s,
                       input logic [1:0] m, input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        issue(d, s, m, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        #12;
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("sll_fff_2",  32'h0000_0FFF, 5'd2,  2'b00, 32'h0000_3FFC, 1);
        run("sra_min_31", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 8);
        run("srl_min_31", 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 8);
        run("rol_8",      32'h1234_5678, 5'd8,  2'b11, 32'h3456_7812, 2);
        run("rol_0",      32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 0);
        run("sra_pos_4",  32'h7FFF_FFFF, 5'd4,  2'b10, 32'h07FF_FFFF, 1);
        run("rol_31",     32'h8000_0001, 5'd31, 2'b11, 32'hC000_0000, 8);
        run("sra_neg_7",  32'hF000_0000, 5'd7,  2'b10, 32'hFFE0_0000, 2);
        run("sll_13",     32'hA5A5_A5A5, 5'd13, 2'b00, 32'hB4B4_A000, 4);
        run("srl_1",      32'hFFFF_FFFF, 5'd1,  2'b01, 32'h7FFF_FFFF, 1);
        run("sll_31",     32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 8);
        run("rol_30",     32'h0000_000F, 5'd30, 2'b11, 32'hC000_0003, 8);

        // Backpressure while a second request is offered.
        issue(32'h0000_0001, 5'd5, 2'b00, lat);
        check("bp_lat", 32'(lat), 32'd2);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_shamt = 5'd3;
        in_mode  = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_vld", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'h0000_0020);
            check("bp_rdy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_vdrop", 32'(out_valid), 32'd0);
        check("bp_rdy_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_no_second", 32'(out_valid), 32'd0);

        // Asynchronous reset two edges into an SRL by 20.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_shamt = 5'd20;
        in_mode  = 2'b01;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("ar_rdy", 32'(in_ready), 32'd1);
        check("ar_vld", 32'(out_valid), 32'd0);
        check("ar_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ar_no_pulse", 32'(out_valid), 32'd0);
        end
        run("ar_sll_3_1", 32'h0000_0003, 5'd1, 2'b00, 32'h0000_0006, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
